// File: rtl/mouse_pkg.sv
// mouse_pkg
// Shared constants and arithmetic helpers for the mouse quadrature counter
// block. Both helpers use 32-bit signed arithmetic. This is wide enough to
// hold any pending value plus one step and one delta without overflow, so the
// saturation decision is always made on the exact result.
package mouse_pkg;

    localparam int CNT_W      = 8;   // width of the JOY0DAT position counters
    localparam int PEND_W_DEF = 11;  // default pending accumulator width
    localparam int DELTA_W    = 10;  // per-report delta after sign handling

    // pend - sub + add, clamped to the signed range of a pend_w-bit register.
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] pend,
        input logic signed [31:0] sub,
        input logic signed [31:0] add,
        input int                 pend_w
    );
        logic signed [31:0] sum;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        sum = pend - sub + add;
        hi  = (32'sd1 <<< (pend_w - 1)) - 32'sd1;
        lo  = -(32'sd1 <<< (pend_w - 1));
        if (sum > hi) begin
            return hi;
        end else if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

    // Limit one drain step to +/-max. A pend of zero gives a step of zero.
    function automatic logic signed [31:0] clamp_step(
        input logic signed [31:0] pend,
        input logic signed [31:0] max
    );
        if (pend > max) begin
            return max;
        end else if (pend < -max) begin
            return -max;
        end
        return pend;
    endfunction

endpackage

// File: rtl/mouse_quadrature_counters_axis.sv
// mouse_axis_accum
// One axis of the quadrature counter block. Holds a saturating signed pending
// accumulator and the 8-bit wrapping position counter. On each tick the
// counter advances by at most MAX_STEP and that amount is removed from pend.
// Ports:
//   clk_30, reset_n : clock and asynchronous active-low reset
//   tick            : drain strobe from the shared divider
//   add_en, delta   : add a signed delta (already in counter direction)
//   load_en,
//   load_val        : overwrite counter bits [7:2] (JOYTEST write)
//   cnt             : position counter
//   nonzero         : registered flag, pend != 0
module mouse_axis_accum
    import mouse_pkg::*;
#(
    parameter int PEND_W   = PEND_W_DEF,
    parameter int MAX_STEP = 8
) (
    input  logic               clk_30,
    input  logic               reset_n,
    input  logic               tick,
    input  logic               add_en,
    input  logic [DELTA_W-1:0] delta,
    input  logic               load_en,
    input  logic [5:0]         load_val,
    output logic [CNT_W-1:0]   cnt,
    output logic               nonzero
);

    logic [PEND_W-1:0]  pend;
    logic [PEND_W-1:0]  pend_next;
    logic signed [31:0] pend_ext;
    logic signed [31:0] delta_ext;
    logic signed [31:0] step;
    logic signed [31:0] sub_amt;
    logic signed [31:0] add_amt;

    // The step comes from the pre-update pend. A report that lands in a tick
    // cycle is added in the same update, so no delta is ever dropped.
    always_comb begin
        pend_ext  = {{(32 - PEND_W){pend[PEND_W-1]}}, pend};
        delta_ext = {{(32 - DELTA_W){delta[DELTA_W-1]}}, delta};
        step      = clamp_step(pend_ext, MAX_STEP);
        sub_amt   = tick ? step : 32'sd0;
        add_amt   = add_en ? delta_ext : 32'sd0;
        pend_next = PEND_W'(sat_add(pend_ext, sub_amt, add_amt, PEND_W));
    end

    // A JOYTEST load takes priority over the tick for the counter. The step
    // of a coinciding tick is still removed from pend, so it is discarded.
    always_ff @(posedge clk_30 or negedge reset_n) begin
        if (!reset_n) begin
            pend    <= '0;
            nonzero <= 1'b0;
            cnt     <= '0;
        end else begin
            pend    <= pend_next;
            nonzero <= (pend_next != '0);
            if (load_en) begin
                cnt <= {load_val, cnt[1:0]};
            end else if (tick) begin
                cnt <= cnt + step[CNT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mouse_quadrature_counters.sv
// mouse_quadrature_counters
// Converts decoded PS/2 movement reports into Amiga JOY0DAT-style wrapping
// position counters and active-low button pins. Large deltas are buffered
// and drained at most MAX_STEP per tick, so the 8-bit counters never alias
// between software reads.
// Ports:
//   clk_30, reset_n      : clock and asynchronous active-low reset
//   mouse_moved          : one-cycle strobe, new report valid
//   mouse_x_move/_y_move : 9-bit signed deltas (right / up positive)
//   mouse_*_button       : button levels, 1 = pressed
//   joytest_write/_data  : JOYTEST register write
//   joy0dat              : {vert_cnt, horiz_cnt}
//   left_n/right_n/
//   middle_n             : registered, inverted buttons
//   pending_nonzero      : either pending accumulator is non-zero
module mouse_quadrature_counters
    import mouse_pkg::*;
#(
    parameter int STEP_DIV = 256,
    parameter int MAX_STEP = 8,
    parameter int PEND_W   = PEND_W_DEF
) (
    input  logic        clk_30,
    input  logic        reset_n,
    input  logic        mouse_moved,
    input  logic [8:0]  mouse_x_move,
    input  logic [8:0]  mouse_y_move,
    input  logic        mouse_left_button,
    input  logic        mouse_right_button,
    input  logic        mouse_middle_button,
    input  logic        joytest_write,
    input  logic [15:0] joytest_data,
    output logic [15:0] joy0dat,
    output logic        left_n,
    output logic        right_n,
    output logic        middle_n,
    output logic        pending_nonzero
);

    logic [15:0]        div;
    logic               tick;
    logic [DELTA_W-1:0] dx;
    logic [DELTA_W-1:0] dy;
    logic [CNT_W-1:0]   horiz_cnt;
    logic [CNT_W-1:0]   vert_cnt;
    logic               nz_x;
    logic               nz_y;
    logic               unused_joytest_bits;

    // Free-running drain divider; a JOYTEST write does not restart it.
    assign tick = (div == 16'(STEP_DIV - 1));

    always_ff @(posedge clk_30 or negedge reset_n) begin
        if (!reset_n) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + 16'd1;
        end
    end

    // Y is negated because the Amiga vertical count increases downward.
    // Ten bits keep the negation of -256 representable.
    assign dx = {mouse_x_move[8], mouse_x_move};
    assign dy = 10'd0 - {mouse_y_move[8], mouse_y_move};

    // JOYTEST bits [9:8] and [1:0] have no counter bits to load.
    assign unused_joytest_bits = ^{joytest_data[9:8], joytest_data[1:0]};

    mouse_axis_accum #(
        .PEND_W   (PEND_W),
        .MAX_STEP (MAX_STEP)
    ) u_axis_x (
        .clk_30   (clk_30),
        .reset_n  (reset_n),
        .tick     (tick),
        .add_en   (mouse_moved),
        .delta    (dx),
        .load_en  (joytest_write),
        .load_val (joytest_data[7:2]),
        .cnt      (horiz_cnt),
        .nonzero  (nz_x)
    );

    mouse_axis_accum #(
        .PEND_W   (PEND_W),
        .MAX_STEP (MAX_STEP)
    ) u_axis_y (
        .clk_30   (clk_30),
        .reset_n  (reset_n),
        .tick     (tick),
        .add_en   (mouse_moved),
        .delta    (dy),
        .load_en  (joytest_write),
        .load_val (joytest_data[15:10]),
        .cnt      (vert_cnt),
        .nonzero  (nz_y)
    );

    // Buttons pass through a single register stage with no debounce.
    always_ff @(posedge clk_30 or negedge reset_n) begin
        if (!reset_n) begin
            left_n   <= 1'b1;
            right_n  <= 1'b1;
            middle_n <= 1'b1;
        end else begin
            left_n   <= ~mouse_left_button;
            right_n  <= ~mouse_right_button;
            middle_n <= ~mouse_middle_button;
        end
    end

    assign joy0dat         = {vert_cnt, horiz_cnt};
    assign pending_nonzero = nz_x | nz_y;

endmodule

// File: tb/tb_mouse_quadrature_counters.sv
// tb_mouse_quadrature_counters
// Self-checking bench. A cycle model pushes the expected outputs into a
// queue on every rising edge, and a monitor pops and compares them on the
// falling edge. Directed scenarios add fixed expected values on top.
module tb_mouse_quadrature_counters;

    localparam int STEP_DIV = 16;
    localparam int MAX_STEP = 8;
    localparam int PEND_W   = 11;
    localparam int PEND_MAX = 1023;
    localparam int PEND_MIN = -1024;

    logic              clk_30 = 1'b0;
    logic              reset_n;
    logic              mouse_moved;
    logic signed [8:0] mouse_x_move;
    logic signed [8:0] mouse_y_move;
    logic              mouse_left_button;
    logic              mouse_right_button;
    logic              mouse_middle_button;
    logic              joytest_write;
    logic [15:0]       joytest_data;
    logic [15:0]       joy0dat;
    logic              left_n;
    logic              right_n;
    logic              middle_n;
    logic              pending_nonzero;

    always #5 clk_30 = ~clk_30;

    mouse_quadrature_counters #(
        .STEP_DIV (STEP_DIV),
        .MAX_STEP (MAX_STEP),
        .PEND_W   (PEND_W)
    ) dut (
        .clk_30              (clk_30),
        .reset_n             (reset_n),
        .mouse_moved         (mouse_moved),
        .mouse_x_move        (mouse_x_move),
        .mouse_y_move        (mouse_y_move),
        .mouse_left_button   (mouse_left_button),
        .mouse_right_button  (mouse_right_button),
        .mouse_middle_button (mouse_middle_button),
        .joytest_write       (joytest_write),
        .joytest_data        (joytest_data),
        .joy0dat             (joy0dat),
        .left_n              (left_n),
        .right_n             (right_n),
        .middle_n            (middle_n),
        .pending_nonzero     (pending_nonzero)
    );

    typedef struct packed {
        logic [15:0] joy;
        logic [2:0]  btn;
        logic        pnz;
    } exp_t;

    exp_t exp_q[$];
    exp_t mdl_e;
    exp_t mon_e;

    int checks = 0;
    int errors = 0;

    int         m_div       = 0;
    int         m_hc        = 0;
    int         m_vc        = 0;
    int         m_px        = 0;
    int         m_py        = 0;
    int         model_ticks = 0;
    logic [2:0] m_btn       = 3'b111;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
        end
    endtask

    function automatic int limitStep(input int p);
        if (p > MAX_STEP) return MAX_STEP;
        if (p < -MAX_STEP) return -MAX_STEP;
        return p;
    endfunction

    function automatic int satPend(input int p);
        if (p > PEND_MAX) return PEND_MAX;
        if (p < PEND_MIN) return PEND_MIN;
        return p;
    endfunction

    // Reference model of one clock cycle, written from the behavioural
    // description with plain integer arithmetic.
    always @(posedge clk_30 or negedge reset_n) begin : model
        int   sx;
        int   sy;
        int   dx;
        int   dy;
        logic t;
        if (!reset_n) begin
            m_div = 0;
            m_hc  = 0;
            m_vc  = 0;
            m_px  = 0;
            m_py  = 0;
            m_btn = 3'b111;
            exp_q.delete();
        end else begin
            t  = (m_div == STEP_DIV - 1);
            dx = mouse_x_move;
            dy = -int'(mouse_y_move);
            sx = t ? limitStep(m_px) : 0;
            sy = t ? limitStep(m_py) : 0;
            m_px = satPend(m_px - sx + (mouse_moved ? dx : 0));
            m_py = satPend(m_py - sy + (mouse_moved ? dy : 0));
            if (joytest_write) begin
                m_hc = (int'(joytest_data[7:0]) & 'hFC) | (m_hc & 3);
                m_vc = (int'(joytest_data[15:8]) & 'hFC) | (m_vc & 3);
            end else if (t) begin
                m_hc = (m_hc + sx) & 255;
                m_vc = (m_vc + sy) & 255;
            end
            m_div = t ? 0 : m_div + 1;
            if (t) model_ticks++;
            m_btn = {~mouse_left_button, ~mouse_right_button, ~mouse_middle_button};
            mdl_e.joy = {8'(m_vc), 8'(m_hc)};
            mdl_e.btn = m_btn;
            mdl_e.pnz = (m_px != 0) || (m_py != 0);
            exp_q.push_back(mdl_e);
        end
    end

    // Compare every expected cycle away from the active edge.
    always @(negedge clk_30) begin
        if (reset_n === 1'b1 && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checkOutput("sb_joy0dat", 32'(joy0dat), 32'(mon_e.joy));
            checkOutput("sb_buttons", 32'({left_n, right_n, middle_n}), 32'(mon_e.btn));
            checkOutput("sb_pending", 32'(pending_nonzero), 32'(mon_e.pnz));
        end
    end

    // Drive one cycle of report and/or JOYTEST write, starting now.
    task automatic applyStimulus(input logic mv, input logic signed [8:0] x,
                                 input logic signed [8:0] y, input logic jw,
                                 input logic [15:0] jd);
        mouse_moved   = mv;
        mouse_x_move  = x;
        mouse_y_move  = y;
        joytest_write = jw;
        joytest_data  = jd;
        @(posedge clk_30);
        #1;
        mouse_moved   = 1'b0;
        mouse_x_move  = '0;
        mouse_y_move  = '0;
        joytest_write = 1'b0;
        joytest_data  = '0;
    endtask

    // Return on the falling edge after n more ticks have occurred.
    task automatic waitTicks(input int n);
        int target;
        target = model_ticks + n;
        for (int i = 0; i < n * STEP_DIV + 4; i++) begin
            @(negedge clk_30);
            if (model_ticks >= target) return;
        end
        checkOutput("tick_timeout", 32'd0, 32'd1);
    endtask

    // Return on the falling edge of the cycle whose next edge is a tick.
    task automatic waitTickCycle();
        for (int i = 0; i < STEP_DIV + 2; i++) begin
            @(negedge clk_30);
            if (m_div == STEP_DIV - 1) return;
        end
        checkOutput("tick_align_timeout", 32'd0, 32'd1);
    endtask

    // Asynchronous reset between edges, checked before any clock edge.
    task automatic resetDut();
        @(posedge clk_30);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_joy0dat", 32'(joy0dat), 32'h0000);
        checkOutput("rst_buttons", 32'({left_n, right_n, middle_n}), 32'b111);
        checkOutput("rst_pending", 32'(pending_nonzero), 32'd0);
        repeat (2) @(posedge clk_30);
        @(negedge clk_30);
        reset_n = 1'b1;
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : main
        int n;
        reset_n             = 1'b0;
        mouse_moved         = 1'b0;
        mouse_x_move        = '0;
        mouse_y_move        = '0;
        mouse_left_button   = 1'b0;
        mouse_right_button  = 1'b0;
        mouse_middle_button = 1'b0;
        joytest_write       = 1'b0;
        joytest_data        = '0;

        $display("[TB] reset state");
        repeat (3) @(posedge clk_30);
        #1;
        checkOutput("init_joy0dat", 32'(joy0dat), 32'h0000);
        checkOutput("init_buttons", 32'({left_n, right_n, middle_n}), 32'b111);
        checkOutput("init_pending", 32'(pending_nonzero), 32'd0);
        @(negedge clk_30);
        reset_n = 1'b1;

        $display("[TB] bounded drain of x = +20");
        applyStimulus(1'b1, 9'sd20, 9'sd0, 1'b0, 16'h0);
        waitTicks(1);
        checkOutput("drain_t1", 32'(joy0dat), 32'h0008);
        checkOutput("drain_t1_pnz", 32'(pending_nonzero), 32'd1);
        waitTicks(1);
        checkOutput("drain_t2", 32'(joy0dat), 32'h0010);
        checkOutput("drain_t2_pnz", 32'(pending_nonzero), 32'd1);
        waitTicks(1);
        checkOutput("drain_t3", 32'(joy0dat), 32'h0014);
        checkOutput("drain_t3_pnz", 32'(pending_nonzero), 32'd0);

        $display("[TB] reset in the middle of a drain");
        applyStimulus(1'b1, 9'sd100, 9'sd0, 1'b0, 16'h0);
        waitTicks(1);
        checkOutput("middrain_cnt", 32'(joy0dat), 32'h001C);
        checkOutput("middrain_pnz", 32'(pending_nonzero), 32'd1);
        resetDut();

        $display("[TB] negative Y and wrap");
        applyStimulus(1'b1, -9'sd1, -9'sd1, 1'b0, 16'h0);
        waitTicks(1);
        checkOutput("wrap_x_down", 32'(joy0dat), 32'h01FF);
        applyStimulus(1'b1, 9'sd0, 9'sd3, 1'b0, 16'h0);
        waitTicks(1);
        checkOutput("wrap_y_up", 32'(joy0dat), 32'hFEFF);
        checkOutput("wrap_pnz", 32'(pending_nonzero), 32'd0);

        $display("[TB] saturation of the pending accumulator");
        resetDut();
        repeat (5) applyStimulus(1'b1, 9'sd255, 9'sd0, 1'b0, 16'h0);
        checkOutput("sat_pnz", 32'(pending_nonzero), 32'd1);
        n = 0;
        while (pending_nonzero && n < 200) begin
            waitTicks(1);
            n++;
        end
        checkOutput("sat_ticks", 32'(n), 32'd128);
        checkOutput("sat_final", 32'(joy0dat), 32'h00FF);

        $display("[TB] report coinciding with a tick");
        resetDut();
        applyStimulus(1'b1, 9'sd10, 9'sd0, 1'b0, 16'h0);
        waitTickCycle();
        applyStimulus(1'b1, 9'sd5, 9'sd0, 1'b0, 16'h0);
        checkOutput("coin_mv_cnt", 32'(joy0dat), 32'h0008);
        checkOutput("coin_mv_pnz", 32'(pending_nonzero), 32'd1);
        waitTicks(1);
        checkOutput("coin_mv_rest", 32'(joy0dat), 32'h000F);
        checkOutput("coin_mv_done", 32'(pending_nonzero), 32'd0);

        $display("[TB] JOYTEST write coinciding with a tick");
        resetDut();
        applyStimulus(1'b1, 9'sd3, 9'sd0, 1'b0, 16'h0);
        waitTicks(1);
        checkOutput("jt_pre", 32'(joy0dat), 32'h0003);
        applyStimulus(1'b1, 9'sd4, 9'sd0, 1'b0, 16'h0);
        waitTickCycle();
        applyStimulus(1'b0, 9'sd0, 9'sd0, 1'b1, 16'hA5A5);
        checkOutput("jt_tick_cnt", 32'(joy0dat), 32'hA4A7);
        checkOutput("jt_tick_pnz", 32'(pending_nonzero), 32'd0);
        waitTicks(1);
        checkOutput("jt_after", 32'(joy0dat), 32'hA4A7);
        applyStimulus(1'b0, 9'sd0, 9'sd0, 1'b1, 16'h0000);
        checkOutput("jt_low_bits", 32'(joy0dat), 32'h0003);

        $display("[TB] buttons");
        @(negedge clk_30);
        mouse_left_button   = 1'b1;
        mouse_right_button  = 1'b0;
        mouse_middle_button = 1'b1;
        #1;
        checkOutput("btn_before", 32'({left_n, right_n, middle_n}), 32'b111);
        @(posedge clk_30);
        #1;
        checkOutput("btn_101", 32'({left_n, right_n, middle_n}), 32'b010);
        mouse_left_button   = 1'b0;
        mouse_right_button  = 1'b1;
        mouse_middle_button = 1'b0;
        @(posedge clk_30);
        #1;
        checkOutput("btn_010", 32'({left_n, right_n, middle_n}), 32'b101);
        mouse_right_button = 1'b0;
        @(posedge clk_30);
        #1;
        checkOutput("btn_000", 32'({left_n, right_n, middle_n}), 32'b111);

        repeat (4) @(negedge clk_30);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mouse_quadrature_counters.md
Name: mouse_quadrature_counters

Overview:
- Consumes the decoded PS/2 movement reports (mouse_moved strobe, 9-bit signed deltas, button levels) from the mouse driver.
- Converts them into Amiga-style 8-bit wrapping horizontal/vertical position counters (JOY0DAT format) and active-low button pins for the chipset register block.
- Large per-packet deltas are buffered in saturating pending accumulators and drained in bounded steps, so the counters never move more than MAX_STEP per drain tick.
- This prevents aliasing of the 8-bit counters between software reads.

Parameters:
- STEP_DIV, 256: clk_30 cycles between drain ticks; range 2..65535.
- MAX_STEP, 8: maximum absolute counter change per axis per tick; range 1..127.
- PEND_W, 11: width of the signed pending accumulators; saturation at ±(2^(PEND_W-1)) bounds.

Ports:
- clk_30  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- mouse_moved  in  1  one-cycle strobe; a new report is valid.
- mouse_x_move  in  9  signed two's-complement X delta; right is positive.
- mouse_y_move  in  9  signed two's-complement Y delta; up is positive.
- mouse_left_button  in  1  level, 1 = pressed.
- mouse_right_button  in  1  level, 1 = pressed.
- mouse_middle_button  in  1  level, 1 = pressed.
- joytest_write  in  1  one-cycle strobe; JOYTEST register write.
- joytest_data  in  16  JOYTEST write data.
- joy0dat  out  16  {vert_cnt[7:0], horiz_cnt[7:0]}.
- left_n  out  1  registered ~left.
- right_n  out  1  registered ~right.
- middle_n  out  1  registered ~middle.
- pending_nonzero  out  1  1 when either pending accumulator ≠ 0.

Behaviour:
- Reset (asynchronous, any time, including mid-drain):
  - horiz_cnt = vert_cnt = 0; pend_x = pend_y = 0; tick divider = 0.
  - left_n = right_n = middle_n = 1; pending_nonzero = 0.
- Buttons: registered once, 1-cycle latency from input to output. No debounce.
- Tick divider:
  - Counts 0..STEP_DIV-1 and wraps.
  - tick is asserted in the cycle where divider = STEP_DIV-1.
  - Free-running; not affected by joytest_write.
- Accumulation on mouse_moved:
  - dx = sign-extended mouse_x_move.
  - dy = −(sign-extended mouse_y_move). Amiga vertical count increases downward.
- Drain step on tick:
  - step = clamp(pend, −MAX_STEP, +MAX_STEP), computed from the pre-update pend. step = 0 if pend = 0.
  - counter <= counter + step[7:0], modulo 256 (wrap at 255→0 and 0→255).
- Pending update each cycle: pend_next = sat(pend − (tick ? step : 0) + (mouse_moved ? d : 0)).
  - Full-precision intermediate, PEND_W+2 bits.
  - Saturate to [−2^(PEND_W−1), 2^(PEND_W−1)−1] (default −1024..1023).
  - A mouse_moved coinciding with a tick is fully applied in the same cycle; nothing is lost.
- Latency: a delta arriving at cycle t first affects the counter at the next tick after t, i.e. at the earliest t+1 when the tick falls at t+1.
- JOYTEST write (one cycle):
  - vert_cnt[7:2] <= joytest_data[15:10]; horiz_cnt[7:2] <= joytest_data[7:2].
  - Bits [1:0] of both counters are unchanged.
  - Pending accumulators are unaffected.
  - If joytest_write and tick coincide, the write wins for the counters that cycle. That tick's step is still subtracted from pend, i.e. discarded.
- joy0dat and pending_nonzero are driven directly from registers; no combinational path from inputs.
- Axes are fully independent; the X and Y datapaths are identical apart from the Y negation.

Decomposition:
- Package mouse_pkg:
  - constant CNT_W = 8; default PEND_W.
  - function sat_add(pend, sub, add) for saturating arithmetic.
  - function clamp_step(pend, max).
- Sub-module mouse_axis_accum, instantiated twice (X, Y).
  - Inputs: clk_30, reset_n, tick, add_en, delta[9:0], load_en, load_val[5:0].
  - Outputs: cnt[7:0], nonzero.
  - Holds the pend and cnt registers.
- Top level holds the tick divider, Y negation, JOYTEST field split and button registers.

Test Plan:
- Reset check: deassert reset_n → joy0dat = 16'h0000, left_n/right_n/middle_n = 1, pending_nonzero = 0. Assert reset_n mid-drain → all values return to reset state immediately.
- Bounded drain: mouse_moved with x = +20, y = 0 → horiz_cnt reads 8, 16, 20 on three successive ticks (MAX_STEP = 8); pend_x = 0 afterwards; pending_nonzero drops after the third tick.
- Negative Y and wrap: y = +3 (up) from vert_cnt = 1 → after one tick vert_cnt = 8'hFE. Separately, x = −1 from horiz_cnt = 0 → 8'hFF.
- Saturation: five reports of x = +255 with no ticks (STEP_DIV large) → pend_x = 1023, not 1275. Drain to completion → horiz_cnt = 1023 mod 256 = 8'hFF.
- Coincidence: mouse_moved x = +5 in the tick cycle with pend_x = 10 → horiz_cnt += 8, pend_x = 7. Separately, joytest_write 16'hA5A5 in a tick cycle with pend_x = 4 and horiz_cnt = 8'h03 → horiz_cnt = 8'hA7, pend_x = 0.
- Buttons: toggle left/right/middle in the pattern 1,0,1 → left_n/right_n/middle_n = 0,1,0 exactly one cycle later.
